// File: rtl/pic_qcycle_controller_pkg.sv
// Shared constants for the PIC midrange Q-cycle controller: opcode match/mask pairs,
// Q-phase encodings and controller state type.
package pic_core_pkg;

  localparam logic [6:0] PCL_ADDR = 7'h02;

  localparam logic [3:0] Q1 = 4'b0001;
  localparam logic [3:0] Q2 = 4'b0010;
  localparam logic [3:0] Q3 = 4'b0100;
  localparam logic [3:0] Q4 = 4'b1000;

  // Each opcode is matched as (instr & MASK) == OP
  localparam logic [13:0] OP_GOTO        = 14'h2800;
  localparam logic [13:0] OP_GOTO_MASK   = 14'h3800;
  localparam logic [13:0] OP_CALL        = 14'h2000;
  localparam logic [13:0] OP_CALL_MASK   = 14'h3800;
  localparam logic [13:0] OP_RETURN      = 14'h0008;
  localparam logic [13:0] OP_RETURN_MASK = 14'h3FFF;
  localparam logic [13:0] OP_RETFIE      = 14'h0009;
  localparam logic [13:0] OP_RETFIE_MASK = 14'h3FFF;
  localparam logic [13:0] OP_RETLW       = 14'h3400;
  localparam logic [13:0] OP_RETLW_MASK  = 14'h3C00;
  localparam logic [13:0] OP_SLEEP       = 14'h0063;
  localparam logic [13:0] OP_SLEEP_MASK  = 14'h3FFF;
  localparam logic [13:0] OP_DECFSZ      = 14'h0B00;
  localparam logic [13:0] OP_DECFSZ_MASK = 14'h3F00;
  localparam logic [13:0] OP_INCFSZ      = 14'h0F00;
  localparam logic [13:0] OP_INCFSZ_MASK = 14'h3F00;
  localparam logic [13:0] OP_BTFSC       = 14'h1800;
  localparam logic [13:0] OP_BTFSC_MASK  = 14'h3C00;
  localparam logic [13:0] OP_BTFSS       = 14'h1C00;
  localparam logic [13:0] OP_BTFSS_MASK  = 14'h3C00;

  typedef enum logic {
    ST_RUN,
    ST_SLEEP
  } ctrl_state_e;

  function automatic logic opMatch(input logic [13:0] instr,
                                   input logic [13:0] op,
                                   input logic [13:0] mask);
    return (instr & mask) == op;
  endfunction

endpackage

// File: rtl/pic_qcycle_controller_if.sv
// Bus between the Q-cycle controller and the rest of the core: instruction/status
// inputs and the phase and strobe outputs.
interface pic_qcycle_if;
  logic [13:0] instr_current;
  logic        alu_zero;
  logic        bit_test;
  logic        wake;
  logic [3:0]  q_phase;
  logic        instr_rd_en;
  logic        incr_pc_en;
  logic        regfile_wr_en;
  logic        w_wr_en;
  logic        status_wr;
  logic        pc_load_en;
  logic        pc_load_src;
  logic        stack_push;
  logic        stack_pop;
  logic        executing_nop;
  logic        sleeping;

  modport master (
    output instr_current, alu_zero, bit_test, wake,
    input  q_phase, instr_rd_en, incr_pc_en, regfile_wr_en, w_wr_en, status_wr,
           pc_load_en, pc_load_src, stack_push, stack_pop, executing_nop, sleeping
  );

  modport slave (
    input  instr_current, alu_zero, bit_test, wake,
    output q_phase, instr_rd_en, incr_pc_en, regfile_wr_en, w_wr_en, status_wr,
           pc_load_en, pc_load_src, stack_push, stack_pop, executing_nop, sleeping
  );
endinterface

// File: rtl/pic_qcycle_controller_decode.sv
// Combinational instruction classifier: maps a 14-bit midrange opcode onto the
// write/branch/skip/sleep classes the Q-cycle controller acts on.
module pic_instr_class_decode
  import pic_core_pkg::*;
(
  input  logic [13:0] instr_i,
  output logic        wr_file_o,
  output logic        wr_w_o,
  output logic        upd_status_o,
  output logic        is_branch_o,
  output logic        is_ret_o,
  output logic        is_call_o,
  output logic        is_skip_z_o,
  output logic        is_skip_bc_o,
  output logic        is_skip_bs_o,
  output logic        is_sleep_o
);

  logic       byteOp;
  logic       bitSetClr;
  logic       literalOp;
  logic [3:0] byteCode;

  // 00_0000_0xxx_xxxx holds NOP/RETURN/SLEEP etc. and is not a byte-oriented op
  assign byteOp    = (instr_i[13:12] == 2'b00) && (instr_i[13:7] != 7'b0000000);
  assign bitSetClr = (instr_i[13:11] == 3'b010);
  assign literalOp = (instr_i[13:12] == 2'b11);
  assign byteCode  = instr_i[11:8];

  assign wr_file_o = (byteOp && instr_i[7]) || bitSetClr;
  assign wr_w_o    = (byteOp && !instr_i[7]) || literalOp;

  // MOVWF, DECFSZ, SWAPF and INCFSZ leave STATUS alone; 11_1011 is unused
  assign upd_status_o = (byteOp && (byteCode != 4'h0) && (byteCode != 4'hB)
                                && (byteCode != 4'hE) && (byteCode != 4'hF))
                     || ((instr_i[13:11] == 3'b111) && (instr_i[10:8] != 3'b011));

  assign is_branch_o  = opMatch(instr_i, OP_GOTO, OP_GOTO_MASK);
  assign is_call_o    = opMatch(instr_i, OP_CALL, OP_CALL_MASK);
  assign is_ret_o     = opMatch(instr_i, OP_RETURN, OP_RETURN_MASK)
                     || opMatch(instr_i, OP_RETFIE, OP_RETFIE_MASK)
                     || opMatch(instr_i, OP_RETLW, OP_RETLW_MASK);
  assign is_skip_z_o  = opMatch(instr_i, OP_DECFSZ, OP_DECFSZ_MASK)
                     || opMatch(instr_i, OP_INCFSZ, OP_INCFSZ_MASK);
  assign is_skip_bc_o = opMatch(instr_i, OP_BTFSC, OP_BTFSC_MASK);
  assign is_skip_bs_o = opMatch(instr_i, OP_BTFSS, OP_BTFSS_MASK);
  assign is_sleep_o   = opMatch(instr_i, OP_SLEEP, OP_SLEEP_MASK);

endmodule

// File: rtl/pic_qcycle_controller.sv
// Q-cycle sequencer for the PIC midrange core: four-phase instruction cycle, fetch/
// PC strobes, Q4 execution strobes, pipeline flush into a forced NOP, and SLEEP/wake.
module pic_qcycle_controller #(
  parameter logic [6:0] PCL_ADDR = pic_core_pkg::PCL_ADDR
) (
  input  logic         clk,
  input  logic         rst,
  pic_qcycle_if.slave  bus
);
  import pic_core_pkg::*;

  ctrl_state_e state_q, state_d;
  logic [3:0]  qPhase_q, qPhase_d;
  logic        flush_q, flush_d;

  logic wrFile, wrW, updStatus, isBranch, isRet, isCall;
  logic isSkipZ, isSkipBc, isSkipBs, isSleep;
  logic pclWrite, flushEvent;

  logic incrPcEn, instrRdEn, regfileWrEn, wWrEn, statusWr;
  logic pcLoadEn, pcLoadSrc, stackPush, stackPop;

  pic_instr_class_decode u_decode (
    .instr_i      (bus.instr_current),
    .wr_file_o    (wrFile),
    .wr_w_o       (wrW),
    .upd_status_o (updStatus),
    .is_branch_o  (isBranch),
    .is_ret_o     (isRet),
    .is_call_o    (isCall),
    .is_skip_z_o  (isSkipZ),
    .is_skip_bc_o (isSkipBc),
    .is_skip_bs_o (isSkipBs),
    .is_sleep_o   (isSleep)
  );

  assign pclWrite   = wrFile && (bus.instr_current[6:0] == PCL_ADDR);
  assign flushEvent = isBranch || isCall || isRet || pclWrite
                   || (isSkipZ && bus.alu_zero)
                   || (isSkipBc && !bus.bit_test)
                   || (isSkipBs && bus.bit_test);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      qPhase_q <= Q1;
      flush_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      qPhase_q <= qPhase_d;
      flush_q  <= flush_d;
    end
  end

  // A forced NOP only clears the flush flag; it can never raise a new one or sleep
  always_comb begin
    state_d     = state_q;
    qPhase_d    = qPhase_q;
    flush_d     = flush_q;
    incrPcEn    = 1'b0;
    instrRdEn   = 1'b0;
    regfileWrEn = 1'b0;
    wWrEn       = 1'b0;
    statusWr    = 1'b0;
    pcLoadEn    = 1'b0;
    pcLoadSrc   = 1'b0;
    stackPush   = 1'b0;
    stackPop    = 1'b0;
    case (state_q)
      ST_RUN: begin
        qPhase_d = {qPhase_q[2:0], qPhase_q[3]};
        if (!rst) begin
          incrPcEn  = qPhase_q[0];
          instrRdEn = qPhase_q[3];
        end
        if (qPhase_q[3]) begin
          if (flush_q) begin
            flush_d = 1'b0;
          end else begin
            flush_d = flushEvent;
            if (isSleep) begin
              state_d = ST_SLEEP;
            end
            if (!rst) begin
              regfileWrEn = wrFile;
              wWrEn       = wrW;
              statusWr    = updStatus;
              pcLoadEn    = isBranch || isCall || isRet;
              pcLoadSrc   = isRet;
              stackPush   = isCall;
              stackPop    = isRet;
            end
          end
        end
      end
      ST_SLEEP: begin
        qPhase_d = Q1;
        if (bus.wake) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d  = ST_RUN;
        qPhase_d = Q1;
      end
    endcase
  end

  assign bus.q_phase       = qPhase_q;
  assign bus.incr_pc_en    = incrPcEn;
  assign bus.instr_rd_en   = instrRdEn;
  assign bus.regfile_wr_en = regfileWrEn;
  assign bus.w_wr_en       = wWrEn;
  assign bus.status_wr     = statusWr;
  assign bus.pc_load_en    = pcLoadEn;
  assign bus.pc_load_src   = pcLoadSrc;
  assign bus.stack_push    = stackPush;
  assign bus.stack_pop     = stackPop;
  assign bus.executing_nop = flush_q && (state_q == ST_RUN);
  assign bus.sleeping      = (state_q == ST_SLEEP);

endmodule

// File: tb/tb_pic_qcycle_controller.sv
// Directed self-checking bench for pic_qcycle_controller: one task per scenario,
// each capturing a full Q1..Q4 instruction cycle and comparing hand-computed patterns.
module tb_pic_qcycle_controller;

  logic clk;
  logic rst;
  int   tests;
  int   failed;

  // Per-cycle captures: bit p holds the signal's value during phase Q(p+1)
  logic [3:0] cIncr, cRd, cRf, cW, cSt, cPl, cSrc, cPush, cPop, cNop;
  logic [15:0] cPhase;

  pic_qcycle_if bus();

  pic_qcycle_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Starts at a negedge inside Q1 and ends at the negedge inside the next Q1
  task automatic runCycle(input logic [13:0] instr, input logic az, input logic bt);
    bus.instr_current = instr;
    bus.alu_zero      = az;
    bus.bit_test      = bt;
    #1;
    for (int p = 0; p < 4; p++) begin
      cPhase[p*4 +: 4] = bus.q_phase;
      cIncr[p] = bus.incr_pc_en;
      cRd[p]   = bus.instr_rd_en;
      cRf[p]   = bus.regfile_wr_en;
      cW[p]    = bus.w_wr_en;
      cSt[p]   = bus.status_wr;
      cPl[p]   = bus.pc_load_en;
      cSrc[p]  = bus.pc_load_src;
      cPush[p] = bus.stack_push;
      cPop[p]  = bus.stack_pop;
      cNop[p]  = bus.executing_nop;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [9:0] strobes;
    rst = 1'b1;
    bus.instr_current = 14'h3000;
    bus.alu_zero = 1'b0;
    bus.bit_test = 1'b0;
    bus.wake = 1'b0;
    repeat (3) @(negedge clk);
    strobes = {bus.incr_pc_en, bus.instr_rd_en, bus.regfile_wr_en, bus.w_wr_en, bus.status_wr,
               bus.pc_load_en, bus.pc_load_src, bus.stack_push, bus.stack_pop, bus.sleeping};
    tests++;
    if (bus.q_phase !== 4'b0001) begin
      failed++;
      $display("[TB] FAIL reset_phase: got %b expected 0001", bus.q_phase);
    end
    tests++;
    if (strobes !== 10'b0) begin
      failed++;
      $display("[TB] FAIL reset_strobes: got %b expected 0000000000", strobes);
    end
    rst = 1'b0;
  endtask

  task automatic test_movlw();
    runCycle(14'h3000, 1'b0, 1'b0);
    tests++;
    if ({cNop, cW, cIncr, cRd} !== {4'b1111, 4'b0000, 4'b0001, 4'b1000}) begin
      failed++;
      $display("[TB] FAIL first_nop: got nop/w/incr/rd %b expected 1111000000011000",
               {cNop, cW, cIncr, cRd});
    end
    runCycle(14'h3000, 1'b0, 1'b0);
    tests++;
    if (cPhase !== 16'h8421) begin
      failed++;
      $display("[TB] FAIL phase_rotate: got %h expected 8421", cPhase);
    end
    tests++;
    if ({cNop, cW, cSt, cRf, cIncr, cRd} !== {4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0001, 4'b1000}) begin
      failed++;
      $display("[TB] FAIL movlw: got nop/w/st/rf/incr/rd %b expected 000010000000000000011000",
               {cNop, cW, cSt, cRf, cIncr, cRd});
    end
  endtask

  task automatic test_addwf();
    runCycle(14'h07A0, 1'b0, 1'b0);
    tests++;
    if ({cRf, cSt, cW, cPl} !== {4'b1000, 4'b1000, 4'b0000, 4'b0000}) begin
      failed++;
      $display("[TB] FAIL addwf: got rf/st/w/pl %b expected 1000100000000000", {cRf, cSt, cW, cPl});
    end
    runCycle(14'h3000, 1'b0, 1'b0);
    tests++;
    if ({cNop, cW} !== {4'b0000, 4'b1000}) begin
      failed++;
      $display("[TB] FAIL addwf_noflush: got nop/w %b expected 00001000", {cNop, cW});
    end
  endtask

  task automatic test_call();
    runCycle(14'h2123, 1'b0, 1'b0);
    tests++;
    if ({cPush, cPl, cSrc, cPop, cRf, cW} !== {4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000}) begin
      failed++;
      $display("[TB] FAIL call: got push/pl/src/pop/rf/w %b expected 100010000000000000000000",
               {cPush, cPl, cSrc, cPop, cRf, cW});
    end
    runCycle(14'h3000, 1'b0, 1'b0);
    tests++;
    if ({cNop, cW} !== {4'b1111, 4'b0000}) begin
      failed++;
      $display("[TB] FAIL call_flush: got nop/w %b expected 11110000", {cNop, cW});
    end
    runCycle(14'h3000, 1'b0, 1'b0);
    tests++;
    if ({cNop, cW} !== {4'b0000, 4'b1000}) begin
      failed++;
      $display("[TB] FAIL call_resume: got nop/w %b expected 00001000", {cNop, cW});
    end
  endtask

  task automatic test_returns();
    runCycle(14'h3455, 1'b0, 1'b0);
    tests++;
    if ({cPop, cPl, cSrc, cPush, cW} !== {4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b1000}) begin
      failed++;
      $display("[TB] FAIL retlw: got pop/pl/src/push/w %b expected 10001000100000001000",
               {cPop, cPl, cSrc, cPush, cW});
    end
    runCycle(14'h0008, 1'b0, 1'b0);
    tests++;
    if ({cNop, cPop, cPl} !== {4'b1111, 4'b0000, 4'b0000}) begin
      failed++;
      $display("[TB] FAIL return_in_nop: got nop/pop/pl %b expected 111100000000", {cNop, cPop, cPl});
    end
    runCycle(14'h0008, 1'b0, 1'b0);
    tests++;
    if ({cNop, cPop, cPl, cSrc, cW} !== {4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b0000}) begin
      failed++;
      $display("[TB] FAIL return: got nop/pop/pl/src/w %b expected 00001000100010000000",
               {cNop, cPop, cPl, cSrc, cW});
    end
    runCycle(14'h3000, 1'b0, 1'b0);
  endtask

  task automatic test_decfsz();
    runCycle(14'h0BA1, 1'b1, 1'b0);
    tests++;
    if ({cRf, cW, cSt} !== {4'b1000, 4'b0000, 4'b0000}) begin
      failed++;
      $display("[TB] FAIL decfsz_taken: got rf/w/st %b expected 100000000000", {cRf, cW, cSt});
    end
    runCycle(14'h3000, 1'b0, 1'b0);
    tests++;
    if ({cNop, cW} !== {4'b1111, 4'b0000}) begin
      failed++;
      $display("[TB] FAIL decfsz_flush: got nop/w %b expected 11110000", {cNop, cW});
    end
    runCycle(14'h0BA1, 1'b0, 1'b0);
    tests++;
    if (cRf !== 4'b1000) begin
      failed++;
      $display("[TB] FAIL decfsz_not_taken: got rf %b expected 1000", cRf);
    end
    runCycle(14'h3000, 1'b0, 1'b0);
    tests++;
    if ({cNop, cW} !== {4'b0000, 4'b1000}) begin
      failed++;
      $display("[TB] FAIL decfsz_noflush: got nop/w %b expected 00001000", {cNop, cW});
    end
  endtask

  task automatic test_bit_skips();
    runCycle(14'h1820, 1'b0, 1'b0);
    tests++;
    if ({cRf, cW, cSt} !== 12'b0) begin
      failed++;
      $display("[TB] FAIL btfsc_strobes: got rf/w/st %b expected 000000000000", {cRf, cW, cSt});
    end
    runCycle(14'h1C20, 1'b0, 1'b0);
    tests++;
    if (cNop !== 4'b1111) begin
      failed++;
      $display("[TB] FAIL btfsc_flush: got nop %b expected 1111", cNop);
    end
    runCycle(14'h1C20, 1'b0, 1'b0);
    runCycle(14'h3000, 1'b0, 1'b0);
    tests++;
    if (cNop !== 4'b0000) begin
      failed++;
      $display("[TB] FAIL btfss_not_taken: got nop %b expected 0000", cNop);
    end
    runCycle(14'h1C20, 1'b0, 1'b1);
    runCycle(14'h3000, 1'b0, 1'b0);
    tests++;
    if ({cNop, cW} !== {4'b1111, 4'b0000}) begin
      failed++;
      $display("[TB] FAIL btfss_taken: got nop/w %b expected 11110000", {cNop, cW});
    end
  endtask

  task automatic test_pcl_write();
    runCycle(14'h0082, 1'b0, 1'b0);
    tests++;
    if ({cRf, cW, cSt} !== {4'b1000, 4'b0000, 4'b0000}) begin
      failed++;
      $display("[TB] FAIL movwf_pcl: got rf/w/st %b expected 100000000000", {cRf, cW, cSt});
    end
    runCycle(14'h0082, 1'b0, 1'b0);
    tests++;
    if ({cNop, cRf} !== {4'b1111, 4'b0000}) begin
      failed++;
      $display("[TB] FAIL movwf_in_nop: got nop/rf %b expected 11110000", {cNop, cRf});
    end
    runCycle(14'h3000, 1'b0, 1'b0);
    tests++;
    if ({cNop, cW} !== {4'b0000, 4'b1000}) begin
      failed++;
      $display("[TB] FAIL nop_no_reflush: got nop/w %b expected 00001000", {cNop, cW});
    end
  endtask

  task automatic test_sleep();
    logic [8:0] anyStrobe;
    logic       badPhase;
    logic       notSleeping;
    runCycle(14'h0063, 1'b0, 1'b0);
    tests++;
    if ({cRf, cW, cSt, cPl} !== 16'b0) begin
      failed++;
      $display("[TB] FAIL sleep_instr: got rf/w/st/pl %b expected 0000000000000000", {cRf, cW, cSt, cPl});
    end
    bus.instr_current = 14'h3000;
    anyStrobe = '0;
    badPhase = 1'b0;
    notSleeping = 1'b0;
    for (int i = 0; i < 20; i++) begin
      anyStrobe |= {bus.incr_pc_en, bus.instr_rd_en, bus.regfile_wr_en, bus.w_wr_en, bus.status_wr,
                    bus.pc_load_en, bus.pc_load_src, bus.stack_push, bus.stack_pop};
      badPhase    |= (bus.q_phase !== 4'b0001);
      notSleeping |= (bus.sleeping !== 1'b1);
      @(negedge clk);
    end
    tests++;
    if ({notSleeping, badPhase, anyStrobe} !== 11'b0) begin
      failed++;
      $display("[TB] FAIL sleep_hold: got notsleep/badphase/strobes %b expected 00000000000",
               {notSleeping, badPhase, anyStrobe});
    end
    bus.wake = 1'b1;
    @(negedge clk);
    bus.wake = 1'b0;
    tests++;
    if ({bus.sleeping, bus.q_phase, bus.incr_pc_en, bus.executing_nop} !== 7'b0_0001_1_0) begin
      failed++;
      $display("[TB] FAIL wake: got sleep/phase/incr/nop %b expected 0000110",
               {bus.sleeping, bus.q_phase, bus.incr_pc_en, bus.executing_nop});
    end
    runCycle(14'h3000, 1'b0, 1'b0);
    tests++;
    if ({cNop, cW, cIncr} !== {4'b0000, 4'b1000, 4'b0001}) begin
      failed++;
      $display("[TB] FAIL wake_resume: got nop/w/incr %b expected 000010000001", {cNop, cW, cIncr});
    end
  endtask

  task automatic test_reset_in_sleep();
    runCycle(14'h0063, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    tests++;
    if (bus.sleeping !== 1'b1) begin
      failed++;
      $display("[TB] FAIL sleep_reentry: got %b expected 1", bus.sleeping);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({bus.sleeping, bus.q_phase, bus.incr_pc_en} !== 6'b0_0001_0) begin
      failed++;
      $display("[TB] FAIL reset_in_sleep: got sleep/phase/incr %b expected 000010",
               {bus.sleeping, bus.q_phase, bus.incr_pc_en});
    end
    rst = 1'b0;
    runCycle(14'h3000, 1'b0, 1'b0);
    tests++;
    if ({cNop, cW} !== {4'b1111, 4'b0000}) begin
      failed++;
      $display("[TB] FAIL reset_nop: got nop/w %b expected 11110000", {cNop, cW});
    end
    runCycle(14'h3000, 1'b0, 1'b0);
    tests++;
    if ({cNop, cW} !== {4'b0000, 4'b1000}) begin
      failed++;
      $display("[TB] FAIL reset_resume: got nop/w %b expected 00001000", {cNop, cW});
    end
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    test_reset();
    test_movlw();
    test_addwf();
    test_call();
    test_returns();
    test_decfsz();
    test_bit_skips();
    test_pcl_write();
    test_sleep();
    test_reset_in_sleep();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
